drum_speed_ramp_controller: RTL and testbench



---
 rtl/washer_pkg.sv | 27 ++
 rtl/ramp_tick_gen.sv | 36 +++
 rtl/drum_speed_ramp_controller.sv | 171 +++++++++++++++++
 tb/tb_drum_speed_ramp_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared washing-machine definitions: drum controller state encoding,
// standard spin speeds and default ramp timing.
package washer_pkg;

  localparam int unsigned SPEED_W = 11;
  localparam int unsigned RETRY_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_BACKOFF   = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_FAULT     = 3'd6
  } drum_state_e;

  localparam logic [SPEED_W-1:0] SPIN_OFF  = 11'd0;
  localparam logic [SPEED_W-1:0] SPIN_LOW  = 11'd400;
  localparam logic [SPEED_W-1:0] SPIN_MED  = 11'd800;
  localparam logic [SPEED_W-1:0] SPIN_HIGH = 11'd1200;
  localparam logic [SPEED_W-1:0] SPIN_MAX  = 11'd1400;

  localparam int unsigned DEF_STEP_RPM = 100;
  localparam int unsigned DEF_TICK_DIV = 5;

endpackage

// File: rtl/ramp_tick_gen.sv
// Prescaler producing one tick every DIV enabled cycles; hold freezes the
// count, clear restarts it.
module ramp_tick_gen #(
  parameter int unsigned DIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q, count_d;
  logic          at_end;

  assign at_end = (count_q == CW'(DIV - 1));
  // Tick must not depend on clear: clear is derived from the parent's next state.
  assign tick   = at_end && !hold;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = at_end ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/drum_speed_ramp_controller.sv
// Drum motor speed sequencer: stepped ramps toward the requested speed,
// vibration back-off with bounded retries, and a latched fault ramp-down.
module drum_speed_ramp_controller
  import washer_pkg::*;
#(
  parameter int unsigned STEP_RPM     = DEF_STEP_RPM,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned BACKOFF_RPM  = 400,
  parameter int unsigned SETTLE_TICKS = 10,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [SPEED_W-1:0] target_speed,
  input  logic               pause,
  input  logic               vibration_sensor,
  output logic [SPEED_W-1:0] drum_motor,
  output logic               at_speed,
  output logic               ramping,
  output logic               vibration_fault,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  drum_state_e        state_q, state_d;
  logic [SPEED_W-1:0] drum_q, drum_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic               at_speed_q, at_speed_d;
  logic               ramping_q, ramping_d;
  logic               fault_q, fault_d;

  logic [SPEED_W-1:0] goal;
  logic               tick, tick_clear, settle_restart, vib_event;
  logic [SPEED_W:0]   up_sum;
  logic signed [SPEED_W:0] dn_diff;
  logic [SPEED_W-1:0] up_next, dn_next, fault_next;

  assign goal = enable ? target_speed : SPIN_OFF;

  // Step arithmetic is one bit wider so neither direction can wrap.
  assign up_sum     = {1'b0, drum_q} + 12'(STEP_RPM);
  assign up_next    = (up_sum > {1'b0, goal}) ? goal : up_sum[SPEED_W-1:0];
  assign dn_diff    = $signed({1'b0, drum_q}) - $signed(12'(STEP_RPM));
  assign dn_next    = (dn_diff < $signed({1'b0, goal})) ? goal : dn_diff[SPEED_W-1:0];
  assign fault_next = dn_diff[SPEED_W] ? SPIN_OFF : dn_diff[SPEED_W-1:0];

  assign vib_event = vibration_sensor && (drum_q > 11'(BACKOFF_RPM)) &&
                     ((state_q == ST_RAMP_UP) || (state_q == ST_HOLD));

  assign tick_clear = (state_q == ST_IDLE) || (state_d != state_q) || settle_restart;

  ramp_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .hold  (pause),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      drum_q     <= SPIN_OFF;
      retry_q    <= '0;
      settle_q   <= '0;
      at_speed_q <= 1'b0;
      ramping_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      drum_q     <= drum_d;
      retry_q    <= retry_d;
      settle_q   <= settle_d;
      at_speed_q <= at_speed_d;
      ramping_q  <= ramping_d;
      fault_q    <= fault_d;
    end
  end

  // Next state; vibration outranks goal changes, which outrank ticks.
  always_comb begin
    state_d        = state_q;
    drum_d         = drum_q;
    retry_d        = retry_q;
    settle_d       = settle_q;
    settle_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drum_d  = SPIN_OFF;
        retry_d = '0;
        if (goal != SPIN_OFF) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP, ST_HOLD: begin
        if (vib_event) begin
          if (retry_q == RETRY_W'(MAX_RETRIES)) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            drum_d  = 11'(BACKOFF_RPM);
            state_d = ST_BACKOFF;
          end
        end else if (goal < drum_q) begin
          state_d = ST_RAMP_DOWN;
        end else if (goal == drum_q) begin
          state_d = (goal == SPIN_OFF) ? ST_IDLE : ST_HOLD;
        end else if (state_q == ST_HOLD) begin
          state_d = ST_RAMP_UP;
        end else if (tick) begin
          drum_d = up_next;
          if (up_next == goal) state_d = ST_HOLD;
        end
      end
      ST_RAMP_DOWN: begin
        if (goal > drum_q) begin
          state_d = ST_RAMP_UP;
        end else if (goal == drum_q) begin
          state_d = (goal == SPIN_OFF) ? ST_IDLE : ST_HOLD;
        end else if (tick) begin
          drum_d = dn_next;
          if (dn_next == goal) state_d = (goal == SPIN_OFF) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_BACKOFF: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_RAMP_DOWN;
        end else if (vibration_sensor) begin
          settle_d       = '0;
          settle_restart = 1'b1;
        end else if (tick) begin
          if (settle_q == SW'(SETTLE_TICKS - 1)) begin
            if (goal > drum_q)      state_d = ST_RAMP_UP;
            else if (goal < drum_q) state_d = ST_RAMP_DOWN;
            else                    state_d = ST_HOLD;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
      end
      ST_FAULT: begin
        if (drum_q == SPIN_OFF) begin
          if (!enable) begin
            state_d = ST_IDLE;
            retry_d = '0;
          end
        end else if (tick) begin
          drum_d = fault_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    at_speed_d = (state_d == ST_HOLD) && (drum_d == goal);
    ramping_d  = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN) ||
                 ((state_d == ST_FAULT) && (drum_d != SPIN_OFF));
    fault_d    = (state_d == ST_FAULT);
  end

  assign drum_motor      = drum_q;
  assign at_speed        = at_speed_q;
  assign ramping         = ramping_q;
  assign vibration_fault = fault_q;
  assign retry_count     = retry_q;

endmodule

// File: tb/tb_drum_speed_ramp_controller.sv
// Scoreboarded bench for the drum speed ramp controller: every drum_motor
// change is matched against a queued (value, cycle) expectation.
module tb_drum_speed_ramp_controller;
  import washer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable, pause, vibration_sensor;
  logic [10:0] target_speed;
  logic [10:0] drum_motor;
  logic        at_speed, ramping, vibration_fault;
  logic [1:0]  retry_count;

  typedef struct {
    logic [10:0] value;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [10:0] prev_drum = '0;
  bit          mon_en = 1'b0;

  drum_speed_ramp_controller dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .target_speed     (target_speed),
    .pause            (pause),
    .vibration_sensor (vibration_sensor),
    .drum_motor       (drum_motor),
    .at_speed         (at_speed),
    .ramping          (ramping),
    .vibration_fault  (vibration_fault),
    .retry_count      (retry_count)
  );

  always #5 clk = ~clk;

  task automatic push(input int v, input int c);
    exp_t e;
    e.value = 11'(v);
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // Advance n cycles; every drum_motor change is scored against the queue head.
  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (drum_motor !== prev_drum) begin
        if (mon_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: drum_motor=%0d at cycle %0d, required no change from %0d",
                     drum_motor, cyc, prev_drum);
          end else begin
            e = exp_q.pop_front();
            if (drum_motor !== e.value || cyc != e.cyc) begin
              errors++;
              $display("FAIL drum_step: drum_motor=%0d at cycle %0d, required %0d at cycle %0d",
                       drum_motor, cyc, e.value, e.cyc);
            end
          end
        end
        prev_drum = drum_motor;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected changes outstanding after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    mon_en           = 1'b0;
    reset            = 1'b1;
    enable           = 1'b0;
    pause            = 1'b0;
    vibration_sensor = 1'b0;
    target_speed     = '0;
    step(2);
    reset = 1'b0;
    step(1);
    prev_drum = drum_motor;
    mon_en    = 1'b1;
  endtask

  // Start a ramp from IDLE and queue each STEP landing up to `upto`.
  task automatic ramp_from_idle(input int tgt, input int upto);
    int n;
    n = cyc;
    enable       = 1'b1;
    target_speed = 11'(tgt);
    for (int i = 1; i * 100 <= upto; i++) push(i * 100, n + 1 + 5 * i);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (drum_motor !== 11'd0) begin errors++; $display("FAIL reset_drum: got %0d, required 0", drum_motor); end
    checks++; if (at_speed !== 1'b0) begin errors++; $display("FAIL reset_at_speed: got %0b, required 0", at_speed); end
    checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL reset_ramping: got %0b, required 0", ramping); end
    checks++; if (vibration_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b, required 0", vibration_fault); end
    checks++; if (retry_count !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d, required 0", retry_count); end
  endtask

  task automatic test_ramp_up();
    do_reset();
    ramp_from_idle(SPIN_LOW, 400);
    step(3);
    checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL ramp_up_ramping: got %0b, required 1", ramping); end
    checks++; if (at_speed !== 1'b0) begin errors++; $display("FAIL ramp_up_at_speed_early: got %0b, required 0", at_speed); end
    wait_drain(40);
    checks++; if (at_speed !== 1'b1) begin errors++; $display("FAIL ramp_up_at_speed: got %0b, required 1", at_speed); end
    checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL ramp_up_hold_ramping: got %0b, required 0", ramping); end
    step(10);
    checks++; if (drum_motor !== 11'd400) begin errors++; $display("FAIL ramp_up_hold: got %0d, required 400", drum_motor); end
  endtask

  task automatic test_ramp_down();
    int m;
    do_reset();
    ramp_from_idle(SPIN_MAX, 1400);
    wait_drain(90);
    m = cyc;
    target_speed = SPIN_MED;
    for (int j = 1; j <= 6; j++) push(1400 - 100 * j, m + 1 + 5 * j);
    wait_drain(45);
    checks++; if (at_speed !== 1'b1) begin errors++; $display("FAIL ramp_down_at_speed: got %0b, required 1", at_speed); end
    // Non-multiple target saturates without overshoot, then drop enable to zero.
    do_reset();
    ramp_from_idle(450, 400);
    push(450, cyc + 26);
    wait_drain(40);
    checks++; if (at_speed !== 1'b1) begin errors++; $display("FAIL sat_at_speed: got %0b, required 1", at_speed); end
    m = cyc;
    enable = 1'b0;
    for (int j = 1; j <= 4; j++) push(450 - 100 * j, m + 1 + 5 * j);
    push(0, m + 26);
    wait_drain(40);
    checks++; if (ramping !== 1'b0 || at_speed !== 1'b0) begin
      errors++; $display("FAIL to_idle: ramping=%0b at_speed=%0b, required 0 0", ramping, at_speed);
    end
  endtask

  task automatic test_vibration();
    int c;
    do_reset();
    ramp_from_idle(SPIN_MAX, SPIN_HIGH);
    wait_drain(80);
    vibration_sensor = 1'b1;
    push(400, cyc + 1);
    step(1);
    vibration_sensor = 1'b0;
    c = cyc;
    checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL vib_retry: got %0d, required 1", retry_count); end
    push(500, c + 56);
    push(600, c + 61);
    wait_drain(80);
    checks++; if (vibration_fault !== 1'b0) begin errors++; $display("FAIL vib_no_fault: got %0b, required 0", vibration_fault); end
  endtask

  task automatic test_fault();
    int f;
    do_reset();
    ramp_from_idle(SPIN_MAX, 500);
    wait_drain(40);
    for (int k = 0; k < 3; k++) begin
      vibration_sensor = 1'b1;
      push(400, cyc + 1);
      step(1);
      vibration_sensor = 1'b0;
      checks++; if (retry_count !== 2'(k + 1)) begin
        errors++; $display("FAIL fault_retry_%0d: got %0d, required %0d", k, retry_count, k + 1);
      end
      push(500, cyc + 56);
      wait_drain(80);
    end
    vibration_sensor = 1'b1;
    step(1);
    vibration_sensor = 1'b0;
    f = cyc;
    checks++; if (vibration_fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %0b, required 1", vibration_fault); end
    checks++; if (retry_count !== 2'd3) begin errors++; $display("FAIL fault_retry_max: got %0d, required 3", retry_count); end
    checks++; if (ramping !== 1'b1) begin errors++; $display("FAIL fault_ramping: got %0b, required 1", ramping); end
    for (int j = 1; j <= 5; j++) push(500 - 100 * j, f + 5 * j);
    wait_drain(40);
    step(5);
    checks++; if (vibration_fault !== 1'b1 || ramping !== 1'b0) begin
      errors++; $display("FAIL fault_hold: fault=%0b ramping=%0b, required 1 0", vibration_fault, ramping);
    end
    enable = 1'b0;
    step(1);
    checks++; if (vibration_fault !== 1'b0 || retry_count !== 2'd0) begin
      errors++; $display("FAIL fault_clear: fault=%0b retry=%0d, required 0 0", vibration_fault, retry_count);
    end
  endtask

  task automatic test_pause();
    int m;
    do_reset();
    ramp_from_idle(SPIN_MAX, 600);
    wait_drain(50);
    m = cyc;
    step(2);
    pause = 1'b1;
    step(23);
    pause = 1'b0;
    checks++; if (drum_motor !== 11'd600) begin errors++; $display("FAIL pause_hold: got %0d, required 600", drum_motor); end
    push(700, m + 28);
    wait_drain(10);
  endtask

  // Vibration lands on the same edge as a ramp tick.
  task automatic test_back_to_back();
    step(4);
    vibration_sensor = 1'b1;
    push(400, cyc + 1);
    step(1);
    vibration_sensor = 1'b0;
    wait_drain(2);
    checks++; if (retry_count !== 2'd1) begin errors++; $display("FAIL vib_tick_retry: got %0d, required 1", retry_count); end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    ramp_from_idle(SPIN_MAX, 300);
    wait_drain(30);
    step(2);
    mon_en = 1'b0;
    reset  = 1'b1;
    step(1);
    checks++; if (drum_motor !== 11'd0 || at_speed !== 1'b0 || ramping !== 1'b0 ||
                  vibration_fault !== 1'b0 || retry_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: drum=%0d at_speed=%0b ramping=%0b fault=%0b retry=%0d, required all 0",
               drum_motor, at_speed, ramping, vibration_fault, retry_count);
    end
    reset  = 1'b0;
    enable = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_vibration();
    test_fault();
    test_pause();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
